// File: rtl/axis_pkg.sv
// axis_pkg: shared pointer-width helper and stored-word type for the stream FIFO
package axis_pkg;
  localparam int AXIS_DW = 32;
  typedef struct packed {
    logic               tlast;
    logic [AXIS_DW-1:0] tdata;
  } axis_word_t;
  function automatic int axis_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: DEPTH-entry array with synchronous write and asynchronous read
module axis_fifo_ram #(
  parameter int W     = 33,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  // store each accepted word; contents need no reset since pointers gate visibility
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI4-Stream FIFO with occupancy/packet counters and optional store-and-forward
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PKT_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [axis_ptr_w(DEPTH)-1:0]     level,
  output logic [axis_ptr_w(DEPTH)-1:0]     pkt_count,
  output logic                             oversize
);
  localparam int PW = axis_ptr_w(DEPTH);
  localparam int AW = PW - 1;
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr, r_level, r_pkt_count;
  logic                r_oversize;
  logic                w_empty, w_full, w_wr_en, w_rd_en, w_ovf_now;
  logic [DATA_WIDTH:0] w_rdata;
  assign w_empty       = r_wr_ptr == r_rd_ptr;
  assign w_full        = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  // ready depends only on registered state, so a read never frees a slot in the same cycle
  assign s_axis_tready = !w_full && !reset;
  // store-and-forward holds output until a whole packet is in, or a full FIFO forces release
  assign m_axis_tvalid = !w_empty && (PKT_MODE == 0 || r_pkt_count != '0 || w_full);
  assign w_wr_en       = s_axis_tvalid && s_axis_tready;
  assign w_rd_en       = m_axis_tvalid && m_axis_tready;
  assign w_ovf_now     = PKT_MODE != 0 && w_full && r_pkt_count == '0;
  assign {m_axis_tlast, m_axis_tdata} = w_rdata;
  assign level         = r_level;
  assign pkt_count     = r_pkt_count;
  assign oversize      = r_oversize || w_ovf_now;
  axis_fifo_ram #(.W(DATA_WIDTH + 1), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata ({s_axis_tlast, s_axis_tdata}),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );
  // advance pointers and counters; simultaneous inc/dec cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pkt_count <= '0;
      r_oversize  <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + PW'(w_wr_en);
      r_rd_ptr    <= r_rd_ptr + PW'(w_rd_en);
      r_level     <= r_level + PW'(w_wr_en) - PW'(w_rd_en);
      r_pkt_count <= r_pkt_count + PW'(w_wr_en && s_axis_tlast) - PW'(w_rd_en && m_axis_tlast);
      r_oversize  <= r_oversize || w_ovf_now;
    end
  end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: scoreboard bench driving a cut-through and a store-and-forward instance
module tb_axis_pkt_fifo;
  import axis_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0][31:0] sd = '0;
  logic [1:0]       sv = '0, sl = '0, mr = '0;
  wire  [1:0][31:0] md;
  wire  [1:0]       sr, mv, ml, ovs;
  wire  [1:0][4:0]  lvl, pc;
  int pass_n = 0, total_n = 0;
  axis_word_t q0[$], q1[$];
  logic [1:0]       hold = '0;
  logic [1:0][31:0] hd = '0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PKT_MODE(g)) u_dut (
      .clk           (clk),
      .reset         (rst),
      .s_axis_tdata  (sd[g]),
      .s_axis_tvalid (sv[g]),
      .s_axis_tready (sr[g]),
      .s_axis_tlast  (sl[g]),
      .m_axis_tdata  (md[g]),
      .m_axis_tvalid (mv[g]),
      .m_axis_tready (mr[g]),
      .m_axis_tlast  (ml[g]),
      .level         (lvl[g]),
      .pkt_count     (pc[g]),
      .oversize      (ovs[g])
    );
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total_n++;
    if (act === want) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
  endtask
  task automatic exp_push(input int m, input logic [31:0] d, input logic l);
    axis_word_t w;
    w.tlast = l;
    w.tdata = d;
    if (m == 0) q0.push_back(w);
    else q1.push_back(w);
  endtask
  task automatic push(input int m, input logic [31:0] d, input logic l);
    bit done = 0;
    sd[m] = d;
    sl[m] = l;
    sv[m] = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (sr[m]) begin
        exp_push(m, d, l);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    sv[m] = 1'b0;
    if (!done) begin
      total_n++;
      $display("FAIL accept_timeout: dut %0d word %0h never accepted", m, d);
    end
  endtask
  task automatic wait_drain(input int m);
    for (int i = 0; i < 100 && lvl[m] != 0; i++) @(negedge clk);
    chk("drain_level", lvl[m], 0);
  endtask
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (hold[m]) begin
        chk("stall_valid", mv[m], 1);
        chk("stall_data", md[m], hd[m]);
      end
      hold[m] = mv[m] && !mr[m] && !rst;
      hd[m] = md[m];
      if (mv[m] && mr[m]) begin
        if ((m == 0 ? q0.size() : q1.size()) == 0) begin
          total_n++;
          $display("FAIL unexpected_output: dut %0d data %0h", m, md[m]);
        end else begin
          axis_word_t e;
          if (m == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk("out_word", {ml[m], md[m]}, {e.tlast, e.tdata});
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", sr[0], 0);
    chk("rst_ready1", sr[1], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", sr[0], 1);
    chk("post_rst_valid", mv[0], 0);
    chk("post_rst_level", lvl[0], 0);
    chk("post_rst_pkt", pc[0], 0);
    chk("post_rst_ovs", ovs[1], 0);
    chk("post_rst_valid1", mv[1], 0);
    // cut-through latency and ordering
    @(posedge clk);
    #1;
    mr[0] = 1'b1;
    sd[0] = 32'd2;
    sl[0] = 1'b0;
    sv[0] = 1'b1;
    @(negedge clk);
    chk("no_bypass", mv[0], 0);
    chk("ready_empty", sr[0], 1);
    exp_push(0, 32'd2, 1'b0);
    @(posedge clk);
    #1 sv[0] = 1'b0;
    @(negedge clk);
    chk("lat_valid", mv[0], 1);
    @(posedge clk);
    #1;
    push(0, 32'd3, 1'b0);
    push(0, 32'd4, 1'b0);
    push(0, 32'd5, 1'b1);
    chk("pc_after_tlast", pc[0], 1);
    wait_drain(0);
    chk("pc_drained", pc[0], 0);
    // fill to full, then one read frees a slot a cycle later
    @(posedge clk);
    #1 mr[0] = 1'b0;
    for (int i = 0; i < 16; i++) push(0, 32'h100 + i, i == 15);
    @(negedge clk);
    chk("full_ready", sr[0], 0);
    chk("full_level", lvl[0], 16);
    chk("full_pc", pc[0], 1);
    @(posedge clk);
    #1 mr[0] = 1'b1;
    @(negedge clk);
    chk("full_read_ready", sr[0], 0);
    @(posedge clk);
    #1 mr[0] = 1'b0;
    chk("ready_back", sr[0], 1);
    chk("level_15", lvl[0], 15);
    // drain to 8, then stream with level held
    mr[0] = 1'b1;
    repeat (7) @(posedge clk);
    #1 mr[0] = 1'b0;
    chk("level_8", lvl[0], 8);
    mr[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(0, 32'h200 + i, i == 9);
      chk("level_hold", lvl[0], 8);
    end
    wait_drain(0);
    chk("pc_after_stream", pc[0], 0);
    // back-pressure mid-packet
    @(posedge clk);
    #1 mr[0] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      push(0, 32'h300 + p * 4, 1'b0);
      push(0, 32'h301 + p * 4, 1'b0);
      mr[0] = 1'b0;
      push(0, 32'h302 + p * 4, 1'b0);
      push(0, 32'h303 + p * 4, 1'b1);
      repeat (5) @(posedge clk);
      #1 mr[0] = 1'b1;
    end
    wait_drain(0);
    chk("pc_after_bp", pc[0], 0);
    // store-and-forward: held until tlast
    @(posedge clk);
    #1 mr[1] = 1'b1;
    push(1, 32'h400, 1'b0);
    push(1, 32'h401, 1'b0);
    push(1, 32'h402, 1'b0);
    @(negedge clk);
    chk("pkt_wait_valid", mv[1], 0);
    chk("pkt_wait_level", lvl[1], 3);
    @(posedge clk);
    #1;
    push(1, 32'h403, 1'b1);
    chk("pkt_valid_rise", mv[1], 1);
    chk("pkt_count_1", pc[1], 1);
    repeat (6) @(posedge clk);
    #1;
    chk("pkt_count_0", pc[1], 0);
    chk("pkt_level_0", lvl[1], 0);
    // oversize: full with no tlast, then reset mid-transfer
    mr[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(1, 32'h500 + i, 1'b0);
      if (i == 14) begin
        chk("ovs_not_full_valid", mv[1], 0);
        chk("ovs_not_full", ovs[1], 0);
      end
    end
    chk("ovs_full_ready", sr[1], 0);
    chk("ovs_full_valid", mv[1], 1);
    chk("ovs_set", ovs[1], 1);
    chk("ovs_level", lvl[1], 16);
    @(posedge clk);
    #1;
    chk("ovs_sticky", ovs[1], 1);
    rst = 1'b1;
    sv[1] = 1'b1;
    sd[1] = 32'hdead;
    sl[1] = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    chk("rst2_ready", sr[1], 0);
    chk("rst2_valid", mv[1], 0);
    chk("rst2_level", lvl[1], 0);
    chk("rst2_pc", pc[1], 0);
    chk("rst2_ovs", ovs[1], 0);
    chk("rst2_ready0", sr[0], 0);
    rst = 1'b0;
    sv[1] = 1'b0;
    @(negedge clk);
    chk("rst2_ready_back", sr[1], 1);
    chk("rst2_valid_low", mv[1], 0);
    chk("rst2_ovs_low", ovs[1], 0);
    repeat (3) @(posedge clk);
    #1;
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Synchronous AXI4-Stream FIFO placed directly downstream of the two-to-one stream mux, absorbing the mux's m_axis output and re-presenting it to the next consumer. It decouples the mux from consumer back-pressure, preserves tdata/tlast ordering, and reports occupancy and stored-packet count. An optional store-and-forward mode holds output until a complete packet (tlast written) is buffered.

## Interface
- DATA_WIDTH, 32, width of tdata.
- DEPTH, 16, number of entries; power of two, at least 4.
- PKT_MODE, 0, 0 = cut-through; 1 = store-and-forward.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- s_axis_tdata  in  DATA_WIDTH  input data from mux m_axis_tdata.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  FIFO can accept a word.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tdata  out  DATA_WIDTH  head-of-FIFO data.
- m_axis_tvalid  out  1  head word presentable.
- m_axis_tready  in  1  consumer ready.
- m_axis_tlast  out  1  head word tlast.
- level  out  $clog2(DEPTH)+1  words stored.
- pkt_count  out  $clog2(DEPTH)+1  complete packets (stored tlast=1 words).
- oversize  out  1  sticky; set when PKT_MODE=1 forces release of a full FIFO with no complete packet.

## Operation
- Storage: DEPTH x (DATA_WIDTH+1) array holding {tlast, tdata}. Write and read pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Pointers wrap naturally modulo 2*DEPTH.
- empty when wr_ptr == rd_ptr. full when the low bits are equal and the MSBs differ.
- Write accept (wr_en) = s_axis_tvalid && s_axis_tready. s_axis_tready = !full && !reset.
- Read accept (rd_en) = m_axis_tvalid && m_axis_tready.
- m_axis_tdata and m_axis_tlast = array[rd_ptr] (asynchronous read, distributed RAM). The values are don't-care when m_axis_tvalid=0.
- m_axis_tvalid:
  - PKT_MODE=0: !empty.
  - PKT_MODE=1: !empty && (pkt_count != 0 || full).
- level: +1 on wr_en only, -1 on rd_en only, unchanged when both occur or neither occurs.
- pkt_count: +1 when wr_en && s_axis_tlast; -1 when rd_en && m_axis_tlast; unchanged when both occur.
- oversize: set on the cycle PKT_MODE=1 && full && pkt_count==0. Cleared only by reset.
- Reset mid-packet discards all contents, including partial packets. There is no recovery of in-flight data.

## Timing
- Reset values: s_axis_tready=0 while reset is high and 1 on the first cycle after; m_axis_tvalid=0; level=0; pkt_count=0; oversize=0; pointers=0. m_axis_tdata/tlast are don't-care.
- Latency, PKT_MODE=0: a word accepted at edge N appears with m_axis_tvalid=1 after edge N (in cycle N+1). There is no combinational path from s_axis to m_axis.
- Latency, PKT_MODE=1: m_axis_tvalid rises the cycle after the tlast word is accepted.
- Full boundary: s_axis_tready=0 when full, even if a read happens in the same cycle. The freed slot becomes visible on the following cycle. Result: one bubble at full; there is no combinational ready path from m_axis_tready.
- Empty boundary: there is no write-to-read bypass. A simultaneous write and read is legal whenever not empty and not full.
- AXI rules:
  - m_axis_tvalid never deasserts without rd_en, except on reset.
  - m_axis_tdata is stable while valid is high and not ready.

## Structure
- Shared package axis_pkg holds:
  - the localparam function for pointer width ($clog2(DEPTH)+1);
  - the struct/typedef for the stored word {tlast, tdata}.
- One natural sub-module: axis_fifo_ram. It contains the DEPTH-entry array with a synchronous write port and an asynchronous read port.
- The top level holds pointers, flags, counters and PKT_MODE gating.

## Test plan
- Reset, then write 4 words (data 2,3,4,5; tlast on 5) with m_axis_tready=1, PKT_MODE=0 -> each word out one cycle after acceptance in order; m_axis_tlast=1 only on 5; level returns to 0; pkt_count returns to 0.
- m_axis_tready=0, push DEPTH=16 words -> s_axis_tready drops after the 16th; level=16. Then raise ready for 1 cycle -> the word pops, s_axis_tready returns one cycle later, and level=15 in that cycle.
- Continuous write and read with ready=1 while level=8 -> level holds at 8 every cycle; output order is intact.
- Back-pressure: ready low for 7 cycles mid-packet of length 4, looping as the mux bench does -> no data lost or duplicated; tdata is stable during stall.
- PKT_MODE=1: write 3 words without tlast -> m_axis_tvalid stays 0. Write the 4th with tlast -> valid rises the next cycle; pkt_count=1, then 0 after the tlast word pops.
- PKT_MODE=1: 16 words without tlast and ready=0 -> oversize=1 and valid=1 when full. Assert reset mid-transfer -> all outputs return to their reset values the next cycle.
